// File: rtl/i8080_bus_bridge_pkg.sv
// Shared constants for the i8080-to-AHB bridge: status bits, FSM encoding, cycle and space types.
// The optional error capture is enabled by defining I8080_BRIDGE_ERR_CAPTURE_EN.
package i8080_bridge_pkg;

  localparam int unsigned CPU_AW = 16;
  localparam int unsigned CPU_DW = 8;
  localparam int unsigned AHB_AW = 32;

  // Bit positions inside the i8080 status word
  localparam int unsigned ST_INTA = 0;
  localparam int unsigned ST_WO_N = 1;
  localparam int unsigned ST_HLTA = 3;
  localparam int unsigned ST_OUT  = 4;
  localparam int unsigned ST_INP  = 6;
  localparam int unsigned ST_MEMR = 7;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STATUS = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_ACCEPT = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  typedef enum logic [1:0] {CYC_RD, CYC_WR, CYC_INTA, CYC_HALT} cyc_e;
  typedef enum logic {SPACE_MEM, SPACE_IO} space_e;

  // Only the status bits the bridge acts on
  typedef struct packed {
    logic memr;
    logic inp;
    logic out;
    logic hlta;
    logic wo_n;
    logic inta;
  } status_t;

  // Map a CPU address into the memory or I/O AHB window
  function automatic logic [AHB_AW-1:0] ahb_map(space_e space, logic [CPU_AW-1:0] addr,
                                                logic [AHB_AW-1:0] mem_base,
                                                logic [AHB_AW-1:0] io_base);
    if (space == SPACE_IO) return io_base + {24'h0, addr[7:0]};
    return mem_base + {16'h0, addr};
  endfunction

endpackage

// File: rtl/i8080_bus_bridge_if.sv
// CPU-side and AHB-request-side signals of the bridge.
// master = bridge view, slave = CPU/AHB environment view.
// Error-capture outputs exist only when I8080_BRIDGE_ERR_CAPTURE_EN is defined.
interface i8080_bus_bridge_if;
  logic        cpu_sync;
  logic        cpu_dbin;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe;
  logic        cpu_ready;
  logic        ahb_read;
  logic        ahb_write;
  logic [31:0] ahb_addr;
  logic [7:0]  ahb_datain;
  logic [7:0]  ahb_dataout;
  logic        ahb_valid;
  logic        ahb_busy;
  logic [1:0]  ahb_resp;
`ifdef I8080_BRIDGE_ERR_CAPTURE_EN
  logic        err_irq;
  logic [31:0] err_addr;

  modport master (
    input  cpu_sync, cpu_dbin, cpu_addr, cpu_data_in, ahb_dataout, ahb_valid, ahb_busy, ahb_resp,
    output cpu_data_out, cpu_data_oe, cpu_ready, ahb_read, ahb_write, ahb_addr, ahb_datain,
           err_irq, err_addr
  );
  modport slave (
    output cpu_sync, cpu_dbin, cpu_addr, cpu_data_in, ahb_dataout, ahb_valid, ahb_busy, ahb_resp,
    input  cpu_data_out, cpu_data_oe, cpu_ready, ahb_read, ahb_write, ahb_addr, ahb_datain,
           err_irq, err_addr
  );
`else
  modport master (
    input  cpu_sync, cpu_dbin, cpu_addr, cpu_data_in, ahb_dataout, ahb_valid, ahb_busy, ahb_resp,
    output cpu_data_out, cpu_data_oe, cpu_ready, ahb_read, ahb_write, ahb_addr, ahb_datain
  );
  modport slave (
    output cpu_sync, cpu_dbin, cpu_addr, cpu_data_in, ahb_dataout, ahb_valid, ahb_busy, ahb_resp,
    input  cpu_data_out, cpu_data_oe, cpu_ready, ahb_read, ahb_write, ahb_addr, ahb_datain
  );
`endif
endinterface

// File: rtl/i8080_bus_bridge_sync_2ff.sv
// Two-flop synchroniser for asynchronous CPU strobes, reset to 0.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Shift the input through the two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/i8080_bus_bridge.sv
// i8080 machine-cycle decoder that turns CPU bus cycles into single-byte AHB requests,
// stalling the CPU through READY until the AHB side completes.
// Define I8080_BRIDGE_ERR_CAPTURE_EN to add err_irq/err_addr error capture.
module i8080_bus_bridge
  import i8080_bridge_pkg::*;
#(
  parameter logic [31:0] MEM_BASE    = 32'h2000_0000,
  parameter logic [31:0] IO_BASE     = 32'h4000_0000,
  parameter logic [7:0]  INTA_VECTOR = 8'hFF
) (
  input  logic              clk,
  input  logic              resetn,
  i8080_bus_bridge_if.master bus
);
  logic sync_s, dbin_s;
  logic sync_prev_q, sync_prev_d, dbin_prev_q, dbin_prev_d;
  logic [2:0]        state_q, state_d;
  cyc_e              cyc_q, cyc_d;
  status_t           status_q, status_d;
  logic [CPU_AW-1:0] addr_q, addr_d;
  logic              ready_q, ready_d;
  logic              oe_q, oe_d;
  logic [CPU_DW-1:0] data_out_q, data_out_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [AHB_AW-1:0] ahb_addr_q, ahb_addr_d;
  logic [CPU_DW-1:0] datain_q, datain_d;
  logic              sync_rise, sync_fall, dbin_fall;
  space_e            space_c;
`ifdef I8080_BRIDGE_ERR_CAPTURE_EN
  logic              err_flag_q, err_flag_d, err_irq_q, err_irq_d;
  logic [AHB_AW-1:0] err_addr_q, err_addr_d;
  logic              err_hit;
`else
  logic              unused_resp;
  assign unused_resp = ^bus.ahb_resp;
`endif

  sync_2ff #(.WIDTH(1)) u_sync_sync (.clk(clk), .resetn(resetn), .d(bus.cpu_sync), .q(sync_s));
  sync_2ff #(.WIDTH(1)) u_sync_dbin (.clk(clk), .resetn(resetn), .d(bus.cpu_dbin), .q(dbin_s));

  assign sync_rise = sync_s & ~sync_prev_q;
  assign sync_fall = ~sync_s & sync_prev_q;
  assign dbin_fall = ~dbin_s & dbin_prev_q;
  assign space_c   = (status_q.inp | status_q.out) ? SPACE_IO : SPACE_MEM;

  // Machine-cycle FSM: next state and registered output values
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    status_d    = status_q;
    addr_d      = addr_q;
    ready_d     = ready_q;
    data_out_d  = data_out_q;
    ahb_addr_d  = ahb_addr_q;
    datain_d    = datain_q;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    sync_prev_d = sync_s;
    dbin_prev_d = dbin_s;
`ifdef I8080_BRIDGE_ERR_CAPTURE_EN
    err_flag_d  = err_flag_q;
    err_irq_d   = 1'b0;
    err_addr_d  = err_addr_q;
    err_hit     = err_flag_q | (bus.ahb_resp != 2'b00);
`endif
    case (state_q)
      S_IDLE: begin
        if (sync_rise) begin
          status_d = '{memr: bus.cpu_data_in[ST_MEMR], inp: bus.cpu_data_in[ST_INP],
                       out: bus.cpu_data_in[ST_OUT], hlta: bus.cpu_data_in[ST_HLTA],
                       wo_n: bus.cpu_data_in[ST_WO_N], inta: bus.cpu_data_in[ST_INTA]};
          addr_d   = bus.cpu_addr;
          ready_d  = 1'b0;
          state_d  = S_STATUS;
        end
      end
      S_STATUS: begin
        if (sync_fall) begin
          if (status_q.inta) begin
            cyc_d      = CYC_INTA;
            data_out_d = INTA_VECTOR;
            ready_d    = 1'b1;
            state_d    = S_DONE;
          end else if (status_q.hlta) begin
            cyc_d   = CYC_HALT;
            ready_d = 1'b1;
            state_d = S_IDLE;
          end else if (status_q.memr | status_q.inp) begin
            cyc_d      = CYC_RD;
            ahb_addr_d = ahb_map(space_c, addr_q, MEM_BASE, IO_BASE);
            state_d    = S_ISSUE;
          end else if (!status_q.wo_n) begin
            cyc_d      = CYC_WR;
            ahb_addr_d = ahb_map(space_c, addr_q, MEM_BASE, IO_BASE);
            datain_d   = bus.cpu_data_in;
            state_d    = S_ISSUE;
          end else begin
            // No bus action implied by the status word: release the CPU
            cyc_d   = CYC_HALT;
            ready_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_ISSUE: begin
        if (!bus.ahb_busy) begin
          rd_d    = (cyc_q == CYC_RD);
          wr_d    = (cyc_q != CYC_RD);
          state_d = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (bus.ahb_busy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if ((cyc_q == CYC_RD) ? bus.ahb_valid : !bus.ahb_busy) begin
          if (cyc_q == CYC_RD) data_out_d = bus.ahb_dataout;
          ready_d = 1'b1;
          state_d = S_DONE;
`ifdef I8080_BRIDGE_ERR_CAPTURE_EN
          err_flag_d = 1'b0;
          if (err_hit) begin
            err_irq_d  = 1'b1;
            err_addr_d = ahb_addr_q;
            if (cyc_q == CYC_RD) data_out_d = 8'hFF;
          end
        end else begin
          err_flag_d = err_hit;
`endif
        end
      end
      S_DONE: begin
        if (cyc_q == CYC_WR || dbin_fall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    oe_d = (state_d == S_DONE) && (cyc_d != CYC_WR) && dbin_s;
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cyc_q       <= CYC_HALT;
      status_q    <= '0;
      addr_q      <= '0;
      ready_q     <= 1'b0;
      oe_q        <= 1'b0;
      data_out_q  <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      ahb_addr_q  <= '0;
      datain_q    <= '0;
      sync_prev_q <= 1'b0;
      dbin_prev_q <= 1'b0;
`ifdef I8080_BRIDGE_ERR_CAPTURE_EN
      err_flag_q  <= 1'b0;
      err_irq_q   <= 1'b0;
      err_addr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      status_q    <= status_d;
      addr_q      <= addr_d;
      ready_q     <= ready_d;
      oe_q        <= oe_d;
      data_out_q  <= data_out_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      ahb_addr_q  <= ahb_addr_d;
      datain_q    <= datain_d;
      sync_prev_q <= sync_prev_d;
      dbin_prev_q <= dbin_prev_d;
`ifdef I8080_BRIDGE_ERR_CAPTURE_EN
      err_flag_q  <= err_flag_d;
      err_irq_q   <= err_irq_d;
      err_addr_q  <= err_addr_d;
`endif
    end
  end

  assign bus.cpu_ready    = ready_q;
  assign bus.cpu_data_oe  = oe_q;
  assign bus.cpu_data_out = data_out_q;
  assign bus.ahb_read     = rd_q;
  assign bus.ahb_write    = wr_q;
  assign bus.ahb_addr     = ahb_addr_q;
  assign bus.ahb_datain   = datain_q;
`ifdef I8080_BRIDGE_ERR_CAPTURE_EN
  assign bus.err_irq      = err_irq_q;
  assign bus.err_addr     = err_addr_q;
`endif
endmodule

// File: tb/tb_i8080_bus_bridge.sv
// Directed bench for i8080_bus_bridge with an AHB master model and request scoreboard.
// Error-capture checks are included when I8080_BRIDGE_ERR_CAPTURE_EN is defined.
module tb_i8080_bus_bridge;
  typedef struct {
    logic        is_rd;
    logic [31:0] addr;
    logic [7:0]  wdata;
  } req_t;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  i8080_bus_bridge_if bus ();

  i8080_bus_bridge dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_req = 0;
  int err_pulses = 0;
  req_t exp_q[$];
  logic [7:0] rd_exp_q[$];

  // AHB model controls
  int         m_waits = 3;
  logic [7:0] m_rdata = 8'h00;
  logic       force_busy = 1'b0;
  logic [1:0] m_err_resp = 2'b00;
  int         m_cnt = 0;
  logic       m_busy = 1'b0;
  logic       m_is_rd = 1'b0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // AHB master model plus request scoreboard
  always @(negedge clk) begin
    req_t r;
    bus.ahb_valid = 1'b0;
    if (!resetn) begin
      m_cnt  = 0;
      m_busy = 1'b0;
    end else begin
      if (m_cnt != 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          if (m_is_rd) begin
            bus.ahb_valid   = 1'b1;
            bus.ahb_dataout = m_rdata;
          end
        end
      end
      if (bus.ahb_read || bus.ahb_write) begin
        n_req++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_req read=%0b addr=%h", bus.ahb_read, bus.ahb_addr);
        end else begin
          r = exp_q.pop_front();
          check("req_is_read", {31'h0, bus.ahb_read}, {31'h0, r.is_rd});
          check("req_is_write", {31'h0, bus.ahb_write}, {31'h0, ~r.is_rd});
          check("req_addr", bus.ahb_addr, r.addr);
          if (!r.is_rd) check("req_wdata", 32'(bus.ahb_datain), 32'(r.wdata));
          check("ready_low_at_req", 32'(bus.cpu_ready), 32'd0);
        end
        m_busy  = 1'b1;
        m_cnt   = m_waits;
        m_is_rd = bus.ahb_read;
      end
    end
    bus.ahb_busy = m_busy | force_busy;
    bus.ahb_resp = m_busy ? m_err_resp : 2'b00;
`ifdef I8080_BRIDGE_ERR_CAPTURE_EN
    if (bus.err_irq === 1'b1) err_pulses++;
`endif
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(output bit ok, output bit early_oe);
    ok = 1'b0;
    early_oe = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.cpu_data_oe === 1'b1 && bus.cpu_ready !== 1'b1) early_oe = 1'b1;
      if (bus.cpu_ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // One complete CPU machine cycle; rd_like cycles raise DBIN and check returned data
  task automatic cpu_cycle(string tag, logic [7:0] st, logic [15:0] a, logic [7:0] d,
                           logic rd_like, logic [7:0] exp_rd);
    bit ok, early;
    logic [7:0] e;
    bus.cpu_addr    = a;
    bus.cpu_data_in = st;
    bus.cpu_sync    = 1'b1;
    if (rd_like) rd_exp_q.push_back(exp_rd);
    step(4);
    check({tag, "_ready_low"}, 32'(bus.cpu_ready), 32'd0);
    check({tag, "_oe_status"}, 32'(bus.cpu_data_oe), 32'd0);
    bus.cpu_sync = 1'b0;
    if (rd_like) bus.cpu_dbin = 1'b1;
    else bus.cpu_data_in = d;
    wait_ready(ok, early);
    check({tag, "_ready_rise"}, 32'(ok), 32'd1);
    check({tag, "_no_early_oe"}, 32'(early), 32'd0);
    if (rd_like) begin
      e = rd_exp_q.pop_front();
      check({tag, "_rdata"}, 32'(bus.cpu_data_out), 32'(e));
      check({tag, "_oe_dbin"}, 32'(bus.cpu_data_oe), 32'd1);
      bus.cpu_dbin = 1'b0;
    end
    step(4);
    check({tag, "_oe_off"}, 32'(bus.cpu_data_oe), 32'd0);
    check({tag, "_ready_hold"}, 32'(bus.cpu_ready), 32'd1);
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_ready"}, 32'(bus.cpu_ready), 32'd0);
    check({tag, "_oe"}, 32'(bus.cpu_data_oe), 32'd0);
    check({tag, "_dout"}, 32'(bus.cpu_data_out), 32'd0);
    check({tag, "_rd"}, 32'(bus.ahb_read), 32'd0);
    check({tag, "_wr"}, 32'(bus.ahb_write), 32'd0);
    check({tag, "_addr"}, bus.ahb_addr, 32'd0);
    check({tag, "_datain"}, 32'(bus.ahb_datain), 32'd0);
`ifdef I8080_BRIDGE_ERR_CAPTURE_EN
    check({tag, "_err_irq"}, 32'(bus.err_irq), 32'd0);
    check({tag, "_err_addr"}, bus.err_addr, 32'd0);
`endif
  endtask

  initial begin
    int n0;
    bit seen;
    bus.cpu_sync    = 1'b0;
    bus.cpu_dbin    = 1'b0;
    bus.cpu_addr    = 16'h0000;
    bus.cpu_data_in = 8'h00;
    #2 resetn = 1'b0;
    step(3);
    check_reset_values("reset");
    resetn = 1'b1;
    step(3);

    // Memory read, data after 3 wait cycles
    n0 = n_req;
    m_waits = 3; m_rdata = 8'hA5;
    exp_q.push_back('{is_rd: 1'b1, addr: 32'h2000_1234, wdata: 8'h00});
    cpu_cycle("memrd", 8'h82, 16'h1234, 8'h00, 1'b1, 8'hA5);
    check("memrd_nreq", 32'(n_req - n0), 32'd1);

    // OUT to port 0x7F
    n0 = n_req;
    exp_q.push_back('{is_rd: 1'b0, addr: 32'h4000_007F, wdata: 8'h3C});
    cpu_cycle("out", 8'h10, 16'h7F7F, 8'h3C, 1'b0, 8'h00);
    check("out_nreq", 32'(n_req - n0), 32'd1);

    // IN from port 0x10
    n0 = n_req;
    m_waits = 2; m_rdata = 8'h5A;
    exp_q.push_back('{is_rd: 1'b1, addr: 32'h4000_0010, wdata: 8'h00});
    cpu_cycle("inp", 8'h42, 16'h1010, 8'h00, 1'b1, 8'h5A);
    check("inp_nreq", 32'(n_req - n0), 32'd1);

    // Interrupt acknowledge: vector without AHB traffic
    n0 = n_req;
    cpu_cycle("inta", 8'h23, 16'h0000, 8'h00, 1'b1, 8'hFF);
    check("inta_nreq", 32'(n_req - n0), 32'd0);

    // Halt acknowledge
    n0 = n_req;
    cpu_cycle("hlta", 8'h8A, 16'h0000, 8'h00, 1'b0, 8'h00);
    check("hlta_nreq", 32'(n_req - n0), 32'd0);

    // Memory write with AHB busy held at issue time
    n0 = n_req;
    m_waits = 2;
    force_busy = 1'b1;
    exp_q.push_back('{is_rd: 1'b0, addr: 32'h2000_BEEF, wdata: 8'h77});
    bus.cpu_addr = 16'hBEEF; bus.cpu_data_in = 8'h00; bus.cpu_sync = 1'b1;
    step(4);
    bus.cpu_sync = 1'b0; bus.cpu_data_in = 8'h77;
    step(12);
    check("busy_hold_nreq", 32'(n_req - n0), 32'd0);
    check("busy_hold_ready", 32'(bus.cpu_ready), 32'd0);
    force_busy = 1'b0;
    step(30);
    check("busy_release_nreq", 32'(n_req - n0), 32'd1);
    check("busy_release_ready", 32'(bus.cpu_ready), 32'd1);

    // Reset while waiting on a long read
    n0 = n_req;
    m_waits = 20;
    exp_q.push_back('{is_rd: 1'b1, addr: 32'h2000_0100, wdata: 8'h00});
    bus.cpu_addr = 16'h0100; bus.cpu_data_in = 8'h82; bus.cpu_sync = 1'b1;
    step(4);
    bus.cpu_sync = 1'b0; bus.cpu_dbin = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step(1);
      seen = (n_req != n0);
    end
    check("rst_wait_req_seen", 32'(seen), 32'd1);
    step(3);
    resetn = 1'b0;
    #1;
    check_reset_values("rst_mid");
    bus.cpu_dbin = 1'b0;
    step(3);
    resetn = 1'b1;
    step(3);
    n0 = n_req;
    m_waits = 3; m_rdata = 8'h11;
    exp_q.push_back('{is_rd: 1'b1, addr: 32'h2000_0001, wdata: 8'h00});
    cpu_cycle("post_rst", 8'h82, 16'h0001, 8'h00, 1'b1, 8'h11);
    check("post_rst_nreq", 32'(n_req - n0), 32'd1);

`ifdef I8080_BRIDGE_ERR_CAPTURE_EN
    // Error response on a memory read
    err_pulses = 0;
    m_waits = 3; m_rdata = 8'h5C; m_err_resp = 2'b01;
    exp_q.push_back('{is_rd: 1'b1, addr: 32'h2000_0042, wdata: 8'h00});
    cpu_cycle("err", 8'h82, 16'h0042, 8'h00, 1'b1, 8'hFF);
    m_err_resp = 2'b00;
    check("err_pulses", 32'(err_pulses), 32'd1);
    check("err_addr", bus.err_addr, 32'h2000_0042);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
